// File: rtl/spi_master_tx.sv
// spi_master_tx
// SPI mode-0 initiator. It accepts a parallel word and a start strobe, drives
// csN/sclk/mosi (MSB first) and returns the word shifted in on miso at the
// end of the transfer.
//
// Parameters:
//   CLKDIV  clk cycles per SCLK half-period (1..255)
//   WIDTH   bits per transfer (2..16)
//
// Ports:
//   clk      system clock, all state changes on posedge
//   reset_n  synchronous active-low reset
//   start    transfer request, honoured only while idle
//   txData   word to send, captured on the accepting edge
//   rxData   last received word, updated together with done
//   busy     high from the cycle after acceptance until the transfer ends
//   done     one-cycle pulse at transfer end
//   csN      chip select, active low
//   sclk     serial clock, idles low
//   mosi     serial data out
//   miso     serial data in (already synchronised)
//
// Build option:
//   SPI_MASTER_LOOPBACK_EN  when defined, the receive shifter takes the
//                           internal mosi bit instead of the miso pin.
module spi_master_tx #(
  parameter int CLKDIV = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  output logic [WIDTH-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             csN,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int              EW        = $clog2(2 * WIDTH);
  localparam logic [7:0]      DIV_LAST  = 8'(CLKDIV - 1);
  localparam logic [EW-1:0]   EDGE_LAST = EW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] txShift, txShiftNext;
  logic [WIDTH-1:0] rxShift, rxShiftNext;
  logic [7:0]       div, divNext;
  logic [EW-1:0]    edges, edgesNext;
  logic [WIDTH-1:0] rxDataNext;
  logic             busyNext, doneNext, csNNext, sclkNext, mosiNext;
  logic             rxIn;

`ifdef SPI_MASTER_LOOPBACK_EN
  // Loopback: the bit currently on the line is what gets captured.
  assign rxIn = mosi;
`else
  assign rxIn = miso;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      txShift <= '0;
      rxShift <= '0;
      div     <= '0;
      edges   <= '0;
      rxData  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      csN     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= stateNext;
      txShift <= txShiftNext;
      rxShift <= rxShiftNext;
      div     <= divNext;
      edges   <= edgesNext;
      rxData  <= rxDataNext;
      busy    <= busyNext;
      done    <= doneNext;
      csN     <= csNNext;
      sclk    <= sclkNext;
      mosi    <= mosiNext;
    end
  end

  always_comb begin
    stateNext   = state;
    txShiftNext = txShift;
    rxShiftNext = rxShift;
    divNext     = div;
    edgesNext   = edges;
    rxDataNext  = rxData;
    busyNext    = busy;
    doneNext    = 1'b0;
    csNNext     = csN;
    sclkNext    = sclk;
    mosiNext    = mosi;

    unique case (state)
      IDLE: begin
        csNNext  = 1'b1;
        sclkNext = 1'b0;
        mosiNext = 1'b0;
        busyNext = 1'b0;
        if (start) begin
          txShiftNext = txData;
          rxShiftNext = '0;
          divNext     = '0;
          edgesNext   = '0;
          stateNext   = SETUP;
        end
      end

      SETUP: begin
        if (csN) begin
          // First SETUP cycle: pins go active while the divider holds at 0,
          // so the full CLKDIV setup time is measured from csN falling.
          csNNext  = 1'b0;
          busyNext = 1'b1;
          mosiNext = txShift[WIDTH-1];
          divNext  = '0;
        end else if (div == DIV_LAST) begin
          divNext     = '0;
          sclkNext    = 1'b1;
          rxShiftNext = {rxShift[WIDTH-2:0], rxIn};
          edgesNext   = EW'(1);
          stateNext   = XFER;
        end else begin
          divNext = div + 8'd1;
        end
      end

      XFER: begin
        if (div == DIV_LAST) begin
          divNext   = '0;
          edgesNext = edges + EW'(1);
          if (!sclk) begin
            sclkNext    = 1'b1;
            rxShiftNext = {rxShift[WIDTH-2:0], rxIn};
          end else begin
            sclkNext = 1'b0;
            if (edges == EDGE_LAST) begin
              // Last falling edge: keep the final bit on mosi through HOLD.
              edgesNext = '0;
              stateNext = HOLD;
            end else begin
              txShiftNext = {txShift[WIDTH-2:0], 1'b0};
              mosiNext    = txShift[WIDTH-2];
            end
          end
        end else begin
          divNext = div + 8'd1;
        end
      end

      HOLD: begin
        sclkNext = 1'b0;
        if (div == DIV_LAST) begin
          divNext    = '0;
          rxDataNext = rxShift;
          doneNext   = 1'b1;
          csNNext    = 1'b1;
          busyNext   = 1'b0;
          mosiNext   = 1'b0;
          stateNext  = IDLE;
        end else begin
          divNext = div + 8'd1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: a default instance (CLKDIV=4, WIDTH=8)
// talking to a small mode-0 slave model, and a CLKDIV=1, WIDTH=9 instance
// with miso tied high.
module tb_spi_master_tx;

  logic clk;
  logic reset_n;

  logic       startA, busyA, doneA, csNA, sclkA, mosiA, misoA;
  logic [7:0] txA, rxA;
  logic       startB, busyB, doneB, csNB, sclkB, mosiB, misoB;
  logic [8:0] txB, rxB;

  spi_master_tx #(.CLKDIV(4), .WIDTH(8)) dutA (
    .clk(clk), .reset_n(reset_n), .start(startA), .txData(txA),
    .rxData(rxA), .busy(busyA), .done(doneA), .csN(csNA),
    .sclk(sclkA), .mosi(mosiA), .miso(misoA)
  );

  spi_master_tx #(.CLKDIV(1), .WIDTH(9)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB), .txData(txB),
    .rxData(rxB), .busy(busyB), .done(doneB), .csN(csNB),
    .sclk(sclkB), .mosi(mosiB), .miso(misoB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // monitor / slave state for dutA
  logic        prevSclkA = 1'b0;
  logic [7:0]  slaveA    = 8'h3C;
  logic        tieLowA   = 1'b0;
  int          riseCntA  = 0;
  logic [15:0] mosiBitsA = '0;
  int          doneCntA  = 0;
  int          busyCntA  = 0;
  // monitor state for dutB
  logic        prevSclkB = 1'b0;
  int          riseCntB  = 0;
  int          firstRiseB  = 0;
  int          secondRiseB = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expRxA(input logic [7:0] tx, input logic [7:0] slaveWord);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return slaveWord;
`endif
  endfunction

  function automatic logic [8:0] expRxB(input logic [8:0] tx);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return 9'h1FF;
`endif
  endfunction

  // Observes outputs on the falling clk edge and plays the slave for dutA:
  // it presents its MSB while selected and shifts after each sclk fall.
  task automatic monitor();
    if (!prevSclkA && sclkA) begin
      riseCntA++;
      mosiBitsA = {mosiBitsA[14:0], mosiA};
    end
    if (prevSclkA && !sclkA) slaveA = {slaveA[6:0], 1'b0};
    if (csNA) slaveA = 8'h3C;
    prevSclkA = sclkA;
    misoA = tieLowA ? 1'b0 : slaveA[7];
    doneCntA += int'(doneA);
    busyCntA += int'(busyA);
    if (!prevSclkB && sclkB) begin
      riseCntB++;
      if (riseCntB == 1) firstRiseB = cyc;
      else if (riseCntB == 2) secondRiseB = cyc;
    end
    prevSclkB = sclkB;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic clearMon();
    riseCntA  = 0;
    mosiBitsA = '0;
    doneCntA  = 0;
    busyCntA  = 0;
  endtask

  task automatic startAGo(input logic [7:0] d, output int e0);
    startA = 1'b1;
    txA    = d;
    tick();
    e0     = cyc;
    startA = 1'b0;
  endtask

  task automatic waitDoneA(input string tag, input int e0, input int expLat);
    int n = 0;
    while (!doneA && n < 300) begin
      tick();
      n++;
    end
    checkEq({tag, "_doneLat"}, doneA ? 32'(cyc - e0) : 32'hFFFF, 32'(expLat));
    $display("xfer %s rx=0x%0h latency=%0d", tag, rxA, cyc - e0);
  endtask

  initial begin
    #2000000;
    $display("FAIL globalTimeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e0;
    int n;
    int gap;
    int firstDone;
    int secondDone;

    reset_n = 1'b0;
    startA = 1'b0; txA = '0; misoA = 1'b0;
    startB = 1'b0; txB = '0; misoB = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // reset state
    checkEq("rstCsN",  csNA,  1);
    checkEq("rstSclk", sclkA, 0);
    checkEq("rstMosi", mosiA, 0);
    checkEq("rstBusy", busyA, 0);
    checkEq("rstDone", doneA, 0);
    checkEq("rstRx",   rxA,   0);

    // basic transfer 0xA5, slave answers 0x3C
    clearMon();
    startAGo(8'hA5, e0);
    tick();
    checkEq("t1CsNLow",  csNA,  0);
    checkEq("t1BusyHi",  busyA, 1);
    checkEq("t1MosiMsb", mosiA, 1);
    waitDoneA("t1", e0, 69);
    checkEq("t1Rx",     rxA, expRxA(8'hA5, 8'h3C));
    checkEq("t1CsNEnd", csNA, 1);
    repeat (2) tick();
    checkEq("t1MosiBits", mosiBitsA[7:0], 8'hA5);
    checkEq("t1Rises",    riseCntA, 8);
    checkEq("t1BusyCyc",  busyCntA, 68);
    checkEq("t1DoneCnt",  doneCntA, 1);

    // start re-asserted mid-transfer is ignored
    clearMon();
    startAGo(8'hA5, e0);
    repeat (9) tick();
    startA = 1'b1;
    txA    = 8'hFF;
    tick();
    startA = 1'b0;
    waitDoneA("t2", e0, 69);
    checkEq("t2Rx", rxA, expRxA(8'hA5, 8'h3C));
    repeat (3) tick();
    checkEq("t2MosiBits", mosiBitsA[7:0], 8'hA5);
    checkEq("t2DoneCnt",  doneCntA, 1);

    // back-to-back with start held high
    clearMon();
    startA = 1'b1;
    txA    = 8'h81;
    tick();
    e0  = cyc;
    txA = 8'h7E;
    n = 0; gap = 0; firstDone = -1; secondDone = -1;
    while (doneCntA < 2 && n < 400) begin
      tick();
      n++;
      if (doneA) begin
        if (firstDone < 0) begin
          firstDone = cyc;
          checkEq("t3Rx1", rxA, expRxA(8'h81, 8'h3C));
          $display("xfer t3a rx=0x%0h latency=%0d", rxA, cyc - e0);
        end else begin
          secondDone = cyc;
          $display("xfer t3b rx=0x%0h latency=%0d", rxA, cyc - e0);
        end
      end
      if (firstDone >= 0 && secondDone < 0 && csNA) gap++;
      if (firstDone >= 0 && !csNA) startA = 1'b0;
    end
    startA = 1'b0;
    checkEq("t3DoneCnt", doneCntA, 2);
    checkEq("t3Done1",   32'(firstDone - e0), 69);
    checkEq("t3Done2",   32'(secondDone - e0), 139);
    checkEq("t3Rx2",     rxA, expRxA(8'h7E, 8'h3C));
    checkEq("t3Gap",     gap, 2);
    checkEq("t3Rises",   riseCntA, 16);
    checkEq("t3MosiBits", mosiBitsA, 16'h817E);
    repeat (3) tick();

    // reset mid-transfer
    clearMon();
    startAGo(8'hA5, e0);
    repeat (29) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkEq("t4CsN",  csNA,  1);
    checkEq("t4Sclk", sclkA, 0);
    checkEq("t4Mosi", mosiA, 0);
    checkEq("t4Busy", busyA, 0);
    checkEq("t4Rx",   rxA,   0);
    repeat (80) tick();
    checkEq("t4NoDone", doneCntA, 0);
    startAGo(8'hC3, e0);
    waitDoneA("t4b", e0, 69);
    checkEq("t4bRx", rxA, expRxA(8'hC3, 8'h3C));
    repeat (2) tick();

    // CLKDIV=1, WIDTH=9, miso tied high
    riseCntB = 0;
    startB = 1'b1;
    txB    = 9'h155;
    tick();
    e0     = cyc;
    startB = 1'b0;
    n = 0;
    while (!doneB && n < 100) begin
      tick();
      n++;
    end
    checkEq("t5DoneLat", doneB ? 32'(cyc - e0) : 32'hFFFF, 20);
    checkEq("t5Rx",      rxB, expRxB(9'h155));
    checkEq("t5Rises",   riseCntB, 9);
    checkEq("t5Period",  32'(secondRiseB - firstRiseB), 2);
    $display("xfer t5 rx=0x%0h latency=%0d", rxB, cyc - e0);
    repeat (2) tick();

    // miso tied low, 0x5A (equals tx only in loopback builds)
    tieLowA = 1'b1;
    tick();
    startAGo(8'h5A, e0);
    waitDoneA("t6", e0, 69);
    checkEq("t6Rx", rxA, expRxA(8'h5A, 8'h00));
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI initiator that drives the serial side of a link whose far end is built around our 8-bit mode-driven shift register (MSB out first, sampled on serial clock rising edges). It accepts a parallel byte plus a start strobe, generates chip-select, SCLK and MOSI in SPI mode 0, and returns the byte simultaneously shifted in on MISO. It sits between the host-side control logic and the off-block SPI pins.

## Interface
- CLKDIV, 4: `clk` cycles per SCLK half-period; legal range 1..255.
- WIDTH, 8: bits per transfer; legal range 2..16.

- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- start  in  1  request a transfer; honoured only in IDLE.
- txData  in  WIDTH  byte to send; captured on the accepting edge.
- rxData  out  WIDTH  last received word; updates only when `done` pulses.
- busy  out  1  high from the cycle after acceptance until the transfer ends.
- done  out  1  one-cycle pulse at transfer end.
- csN  out  1  chip select, active low.
- sclk  out  1  serial clock, idles low.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in; assumed synchronised externally.

## Operation
- Internal state: tx shift register, rx shift register, half-period counter `div` (0..CLKDIV-1), edge counter `edges` (0..2*WIDTH-1).
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE: csN=1, sclk=0, mosi=0, busy=0. On `start`=1: load tx from `txData`, clear rx, clear `div`, go SETUP.
- SETUP: csN=0, mosi=tx[WIDTH-1], sclk=0. After CLKDIV cycles go XFER with sclk toggling high.
- XFER: every CLKDIV cycles sclk toggles, `edges` increments.
  - Rising edge (sclk 0->1): rx <= {rx[WIDTH-2:0], miso} on that same clk edge.
  - Falling edge (sclk 1->0): tx shifts left, mosi <= new tx[WIDTH-1]; on the final falling edge (edges == 2*WIDTH-1) tx is not shifted and go HOLD.
- HOLD: csN stays 0, sclk 0, for CLKDIV cycles; then go IDLE, rxData <= rx, done=1 for one cycle, csN=1, busy=0.
- `start` while not IDLE: ignored, no queuing.
- `start` on the same cycle as `done`: ignored (FSM is in HOLD when sampled); accepted on the next cycle.
- `txData` changes after acceptance have no effect on the current transfer.

## Timing
- Accepting edge E0 (IDLE, start=1). Cycle numbers below are clk edges after E0.
- E0+1: csN=0, busy=1, mosi=txData[WIDTH-1].
- First SCLK rise at E0+1+CLKDIV; SCLK edge k (k=0..2*WIDTH-1) at E0+1+(k+1)*CLKDIV.
- Last falling edge at E0+1+2*WIDTH*CLKDIV.
- csN=1, busy=0, done=1, rxData valid at E0+1+(2*WIDTH+1)*CLKDIV. For defaults: E0+69.
- Minimum start-to-start spacing: (2*WIDTH+1)*CLKDIV+2 cycles.
- Reset (reset_n=0 at a posedge), including mid-transfer: next cycle csN=1, sclk=0, mosi=0, busy=0, done=0, rxData=0, FSM=IDLE; partial transfer discarded, no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: rx shift input takes internal mosi instead of `miso` pin (`miso` ignored); rxData equals txData after each transfer. Pin outputs unchanged.
- Not defined: rx samples the `miso` pin as above.

## Test plan
- Defaults, txData=0xA5, slave model returns 0x3C on miso: mosi bits 1,0,1,0,0,1,0,1 at rising edges; rxData=0x3C and done at E0+69; busy high exactly 68 cycles.
- start re-asserted at E0+10 with txData=0xFF: ignored; mosi sequence still 0xA5; single done pulse.
- Back-to-back: start held high continuously with 0x81 then 0x7E: two transfers, csN high ≥1 cycle between, rxData updates twice, 16 rising edges total.
- reset_n low at E0+30: next cycle csN=1, sclk=0, busy=0, rxData=0; no done pulse; new start then completes normally.
- CLKDIV=1, WIDTH=9, txData=0x155, miso tied 1: done at E0+20, rxData=0x1FF, sclk period 2 cycles.
- With SPI_MASTER_LOOPBACK_EN, miso tied 0, txData=0x5A: rxData=0x5A.
